// File: rtl/fft_reorder_buffer.sv
// fft_reorder_buffer: ping-pong frame buffer converting bit-reversed FFT
// output order into natural order. Each incoming sample k is written at
// address bitrev(k) of the write bank; a full bank is read out linearly.
// Writing one bank while reading the other sustains one sample per cycle.
module fft_reorder_buffer #(
  parameter int WIDTH = 32,
  parameter int LOG2N = 3
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             out_last
);

  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] LAST_IDX = '1;

  logic             wr_sel, rd_sel;
  logic [LOG2N-1:0] wr_cnt, rd_cnt;
  logic [1:0]       full, full_nxt;
  logic             wr_fire, rd_fire, wr_wrap, rd_wrap;
  logic [LOG2N-1:0] wr_addr;
  logic [1:0][WIDTH-1:0] rd_word;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction

  // in_ready depends only on registered state, so out_ready never reaches it
  assign in_ready  = ~full[wr_sel];
  assign out_valid = full[rd_sel];
  assign out_last  = out_valid & (rd_cnt == LAST_IDX);
  assign out_data  = out_valid ? rd_word[rd_sel] : '0;

  assign wr_fire = in_valid & in_ready;
  assign rd_fire = out_valid & out_ready;
  assign wr_wrap = wr_fire & (wr_cnt == LAST_IDX);
  assign rd_wrap = rd_fire & (rd_cnt == LAST_IDX);
  assign wr_addr = bitrev(wr_cnt);

  // Two banks, no reset on contents; a write only lands in the selected bank
  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic [WIDTH-1:0] mem [N];

    // bank write port
    always_ff @(posedge clk) begin
      if (wr_fire && (wr_sel == 1'(b))) mem[wr_addr] <= in_data;
    end

    assign rd_word[b] = mem[rd_cnt];
  end

  // Bank occupancy: a frame completing and a frame draining on the same edge
  // touch different banks, so both updates are applied independently.
  always_comb begin
    full_nxt = full;
    if (wr_wrap) full_nxt[wr_sel] = 1'b1;
    if (rd_wrap) full_nxt[rd_sel] = 1'b0;
  end

  // Control state: counters, bank selectors and occupancy flags
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      wr_cnt <= '0;
      rd_cnt <= '0;
      full   <= '0;
    end else begin
      full <= full_nxt;
      if (wr_fire) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (wr_wrap) wr_sel <= ~wr_sel;
      end
      if (rd_fire) begin
        rd_cnt <= rd_cnt + 1'b1;
        if (rd_wrap) rd_sel <= ~rd_sel;
      end
    end
  end

endmodule

// File: doc/fft_reorder_buffer.md
FFT_REORDER_BUFFER -- requirements
Module: fft_reorder_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, sample width in bits.
REQ-002 SHALL have parameter LOG2N, default 3, log2 of frame length N = 2**LOG2N.
REQ-003 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-004 SHALL have port clear_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, upstream sample valid.
REQ-006 SHALL have port in_data, input, WIDTH, sample in bit-reversed frame order.
REQ-007 SHALL have port in_ready, output, 1, buffer can accept a sample.
REQ-008 SHALL have port out_valid, output, 1, output sample valid.
REQ-009 SHALL have port out_data, output, WIDTH, sample in natural frame order.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts the sample.
REQ-011 SHALL have port out_last, output, 1, high with the final sample (index N-1) of each frame.

Function
REQ-012 SHALL hold two banks of N words each (ping-pong), plus wr_sel, rd_sel, wr_cnt[LOG2N-1:0], rd_cnt[LOG2N-1:0], and full[1:0].
REQ-013 SHALL accept a sample only on in_valid & in_ready at a clk rising edge, and SHALL write it to bank wr_sel at address bitrev(wr_cnt).
REQ-014 SHALL increment wr_cnt on each accepted write; on the write with wr_cnt = N-1 it SHALL wrap wr_cnt to 0, set full[wr_sel] and toggle wr_sel.
REQ-015 SHALL drive in_ready = ~full[wr_sel] from registered state only, with no combinational path from out_ready.
REQ-016 SHALL drive out_valid = full[rd_sel], and out_data = bank rd_sel at address rd_cnt when out_valid is high, else all zeros.
REQ-017 SHALL drive out_last = out_valid & (rd_cnt == N-1).
REQ-018 SHALL advance rd_cnt on each out_valid & out_ready; on the transfer with out_last high it SHALL wrap rd_cnt to 0, clear full[rd_sel] and toggle rd_sel.
REQ-019 SHALL hold out_data, out_last and out_valid stable while out_valid & ~out_ready.
REQ-020 SHALL present the first sample of a frame on the cycle after the edge that accepts that frame's N-th input (latency 1 cycle).
REQ-021 SHALL allow a frame write and an earlier frame read to proceed in the same cycle on opposite banks, sustaining 1 sample/cycle.
REQ-022 If the last read of bank X and the last write of bank Y occur on the same edge, both SHALL take effect: full[X] is cleared, full[Y] is set, and both selectors toggle.
REQ-023 A bank freed by a final read SHALL raise in_ready no earlier than the following cycle.
REQ-024 When both banks are full, in_ready SHALL be 0 and no write SHALL alter memory or counters.
REQ-025 Bank memory contents SHALL NOT need to be reset. Only the control state and the outputs are defined after reset.

Reset
REQ-026 While clear_n = 0, wr_sel, rd_sel, wr_cnt, rd_cnt and full SHALL be 0, giving in_ready = 1, out_valid = 0, out_last = 0 and out_data = 0, independent of clk.
REQ-027 Asserting clear_n mid-frame SHALL discard all partial and full frames. The first accepted sample after release SHALL be treated as index 0.

Verification
REQ-028 N=8, no backpressure, input 0,4,2,6,1,5,3,7 -> output 0..7, out_last on 7, first out_valid one cycle after the 8th input is accepted.
REQ-029 Three back-to-back frames with out_ready = 1 -> in_ready stays 1 throughout, and each output frame is in natural order.
REQ-030 out_ready = 0 while two frames are written -> in_ready drops after the 16th accepted sample, and a 17th in_valid is not accepted. After one out_ready = 1 frame, in_ready returns the cycle after out_last.
REQ-031 Random out_ready toggling -> out_data held stable while stalled, and no sample is lost or duplicated over 10 frames.
REQ-032 clear_n pulsed low after 5 inputs, then a full frame supplied -> out_valid = 0 during reset, and only the post-reset frame is output, correctly ordered.
REQ-033 Final read of one bank on the same edge as the final write of the other -> both frames remain correct, and out_valid stays 1 across the frame boundary.
